gcd_reduce: RTL and testbench

Fraction-reduction stage built around the `gcd` unit: accepts a signed numerator/denominator pair and issues it to an external `gcd` instance. It then consumes that unit's result and divides both operands by the GCD using a bit-serial restoring divider. It emits the reduced fraction with a sign-normalised denominator. It sits between the operand source and the `gcd` engine, acting as the `gcd`'s upstream driver and its downstream result consumer.

---
 rtl/gcd_reduce_if.sv | 63 ++++++
 rtl/gcd_reduce.sv | 237 +++++++++++++++++++++++
 tb/tb_gcd_reduce.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/gcd_reduce_if.sv
// gcd_reduce_if
//   Bundles the gcd_reduce signals: the operand handshake from the source,
//   the issue/result handshake with the external gcd engine, and the
//   reduced-fraction handshake to the downstream consumer.
//
// Parameters
//   N                     operand width; must match the attached gcd engine
//
// Signals
//   in_num / in_den       signed numerator / denominator from the source
//   in_valid / in_ready   operand handshake
//   gcd_a / gcd_b         operands presented to the gcd engine
//   gcd_input_available   operands offered to the gcd engine
//   gcd_idle              gcd engine ready to take operands
//   gcd_result_available  gcd engine result valid
//   gcd_result_taken      result consumed by the reducer
//   gcd_out               unsigned gcd magnitude
//   out_num               signed reduced numerator, N+1 bits
//   out_den               unsigned reduced denominator
//   out_undef             original denominator was zero
//   out_valid / out_ready result handshake
//
// Modports
//   master  view used by gcd_reduce itself
//   slave   view of the surrounding environment (source, gcd engine, sink)
interface gcd_reduce_if #(
  parameter int N = 8
);
  logic [N-1:0] in_num;
  logic [N-1:0] in_den;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] gcd_a;
  logic [N-1:0] gcd_b;
  logic         gcd_input_available;
  logic         gcd_idle;
  logic         gcd_result_available;
  logic         gcd_result_taken;
  logic [N-1:0] gcd_out;
  logic [N:0]   out_num;
  logic [N-1:0] out_den;
  logic         out_undef;
  logic         out_valid;
  logic         out_ready;

  modport master (
    input  in_num, in_den, in_valid,
    input  gcd_idle, gcd_result_available, gcd_out,
    input  out_ready,
    output in_ready,
    output gcd_a, gcd_b, gcd_input_available, gcd_result_taken,
    output out_num, out_den, out_undef, out_valid
  );

  modport slave (
    output in_num, in_den, in_valid,
    output gcd_idle, gcd_result_available, gcd_out,
    output out_ready,
    input  in_ready,
    input  gcd_a, gcd_b, gcd_input_available, gcd_result_taken,
    input  out_num, out_den, out_undef, out_valid
  );
endinterface

// File: rtl/gcd_reduce.sv
// gcd_reduce
//   Fraction reduction stage. Captures a signed numerator/denominator pair,
//   hands it to an external gcd engine, takes the gcd back and divides the
//   magnitudes of both operands by it with a bit-serial restoring divider
//   (one quotient bit per cycle). The reduced fraction is emitted with the
//   sign carried entirely by the numerator and an unsigned denominator.
//
// Ports
//   clk    rising-edge clock
//   reset  asynchronous, active-low reset
//   bus    gcd_reduce_if.master: operand input, gcd engine link, result output
//
// Configuration
//   GCD_REDUCE_UNITY_BYPASS_EN  when defined, a gcd of 1 skips the divider and
//                               the magnitudes are emitted directly; when
//                               undefined, g==1 takes the full divide path.
//                               Values are identical, only latency differs.
module gcd_reduce #(
  parameter int N = 8
) (
  input logic         clk,
  input logic         reset,
  gcd_reduce_if.master bus
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

`ifdef GCD_REDUCE_UNITY_BYPASS_EN
  localparam bit UnityBypass = 1'b1;
`else
  localparam bit UnityBypass = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    DIV_NUM,
    DIV_DEN,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  num_q, num_d;
  logic [N-1:0]  den_q, den_d;
  logic          sneg_q, sneg_d;
  logic          undef_q, undef_d;
  logic [N-1:0]  g_q, g_d;
  logic [N-1:0]  qNum_q, qNum_d;
  logic [N-1:0]  div_q, div_d;
  logic [N-1:0]  rem_q, rem_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N:0]    outNum_q, outNum_d;
  logic [N-1:0]  outDen_q, outDen_d;
  logic          outUndef_q, outUndef_d;

  logic [N-1:0]  absNum;
  logic [N-1:0]  absDen;
  logic [N:0]    trial;
  logic          fits;
  logic [N-1:0]  remStep;
  logic [N-1:0]  divStep;
  logic          lastStep;

  // Attach the fraction sign to an unsigned magnitude. One extra bit keeps
  // +2^(N-1) representable, which arises from |-2^(N-1)| / 1.
  function automatic logic [N:0] applySign(input logic neg, input logic [N-1:0] mag);
    logic [N:0] wide;
    wide = {1'b0, mag};
    return neg ? (~wide + (N+1)'(1)) : wide;
  endfunction

  // Magnitudes as N-bit unsigned values; the most negative operand maps to
  // 2^(N-1), which still fits in N unsigned bits.
  always_comb begin
    absNum = num_q[N-1] ? (~num_q + N'(1)) : num_q;
    absDen = den_q[N-1] ? (~den_q + N'(1)) : den_q;
  end

  // One restoring-division step: shift the next dividend bit into the
  // partial remainder, subtract the divisor when it fits and shift the
  // resulting quotient bit into the vacated low end of the dividend register.
  // The partial remainder is always below g, so the subtraction result fits
  // in N bits and the top bit of the trial value only matters for the compare.
  always_comb begin
    trial    = {rem_q, div_q[N-1]};
    fits     = (trial >= {1'b0, g_q});
    remStep  = fits ? (trial[N-1:0] - g_q) : trial[N-1:0];
    divStep  = {div_q[N-2:0], fits};
    lastStep = (cnt_q == CW'(N - 1));
  end

  // State and datapath registers. Everything clears on reset, which drops
  // any operation in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      num_q      <= '0;
      den_q      <= '0;
      sneg_q     <= 1'b0;
      undef_q    <= 1'b0;
      g_q        <= '0;
      qNum_q     <= '0;
      div_q      <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
      outNum_q   <= '0;
      outDen_q   <= '0;
      outUndef_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      num_q      <= num_d;
      den_q      <= den_d;
      sneg_q     <= sneg_d;
      undef_q    <= undef_d;
      g_q        <= g_d;
      qNum_q     <= qNum_d;
      div_q      <= div_d;
      rem_q      <= rem_d;
      cnt_q      <= cnt_d;
      outNum_q   <= outNum_d;
      outDen_q   <= outDen_d;
      outUndef_q <= outUndef_d;
    end
  end

  // Next-state and datapath control. The divider is shared: the numerator
  // magnitude goes through first, its quotient is parked in qNum, then the
  // denominator magnitude is loaded and its quotient goes straight to the
  // output register on the way into DONE.
  always_comb begin
    state_d    = state_q;
    num_d      = num_q;
    den_d      = den_q;
    sneg_d     = sneg_q;
    undef_d    = undef_q;
    g_d        = g_q;
    qNum_d     = qNum_q;
    div_d      = div_q;
    rem_d      = rem_q;
    cnt_d      = cnt_q;
    outNum_d   = outNum_q;
    outDen_d   = outDen_q;
    outUndef_d = outUndef_q;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          num_d   = bus.in_num;
          den_d   = bus.in_den;
          // A zero numerator must come out as non-negative zero.
          sneg_d  = (bus.in_num != '0) && (bus.in_num[N-1] ^ bus.in_den[N-1]);
          undef_d = (bus.in_den == '0);
          state_d = ISSUE;
        end
      end

      ISSUE: begin
        if (bus.gcd_idle) begin
          state_d = WAIT;
        end
      end

      WAIT: begin
        if (bus.gcd_result_available) begin
          g_d = bus.gcd_out;
          if (bus.gcd_out == '0) begin
            // Only 0/0 produces a zero gcd; there is nothing to divide.
            outNum_d   = '0;
            outDen_d   = '0;
            outUndef_d = undef_q;
            state_d    = DONE;
          end else if (UnityBypass && (bus.gcd_out == N'(1))) begin
            outNum_d   = applySign(sneg_q, absNum);
            outDen_d   = absDen;
            outUndef_d = undef_q;
            state_d    = DONE;
          end else begin
            div_d   = absNum;
            rem_d   = '0;
            cnt_d   = '0;
            state_d = DIV_NUM;
          end
        end
      end

      DIV_NUM: begin
        div_d = divStep;
        rem_d = remStep;
        cnt_d = cnt_q + CW'(1);
        if (lastStep) begin
          qNum_d  = divStep;
          div_d   = absDen;
          rem_d   = '0;
          cnt_d   = '0;
          state_d = DIV_DEN;
        end
      end

      DIV_DEN: begin
        div_d = divStep;
        rem_d = remStep;
        cnt_d = cnt_q + CW'(1);
        if (lastStep) begin
          cnt_d      = '0;
          outNum_d   = applySign(sneg_q, qNum_q);
          outDen_d   = divStep;
          outUndef_d = undef_q;
          state_d    = DONE;
        end
      end

      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // in_ready is qualified with reset so it stays low while reset is held and
  // comes up as soon as reset is released, the state already being IDLE.
  assign bus.in_ready            = (state_q == IDLE) && reset;
  assign bus.gcd_input_available = (state_q == ISSUE);
  assign bus.gcd_result_taken    = (state_q == WAIT) && bus.gcd_result_available;
  assign bus.out_valid           = (state_q == DONE);
  assign bus.gcd_a               = num_q;
  assign bus.gcd_b               = den_q;
  assign bus.out_num             = outNum_q;
  assign bus.out_den             = outDen_q;
  assign bus.out_undef           = outUndef_q;

endmodule

// File: tb/tb_gcd_reduce.sv
// tb_gcd_reduce
//   Directed bench for gcd_reduce with N=8. The bench plays the operand
//   source, the gcd engine (returning hand-computed gcd values) and the
//   result sink. Inputs change on the falling edge and outputs are sampled
//   on the falling edge, away from the active rising edge.
module tb_gcd_reduce;

  localparam int N = 8;
  localparam int FullLat = 2 * N + 1;
`ifdef GCD_REDUCE_UNITY_BYPASS_EN
  localparam int UnityLat = 1;
`else
  localparam int UnityLat = 2 * N + 1;
`endif

  logic clk;
  logic reset;
  int   testsRun;
  int   failCount;
  int   lat;

  gcd_reduce_if #(.N(N)) bus ();

  gcd_reduce #(.N(N)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.master)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something stalls outside the bounded waits.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // One comparison: counts it and reports tag/observed/expected on a miss.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Runs one operand pair up to the first cycle with out_valid high.
  // The gcd engine stays busy one ISSUE cycle, then the result shows up one
  // cycle into WAIT. lat counts cycles from the result-taken cycle.
  task automatic applyStimulus(input logic [N-1:0] num, input logic [N-1:0] den,
                               input logic [N-1:0] g, output int latOut);
    int waitCnt;
    waitCnt = 0;
    while (!bus.in_ready && waitCnt < 20) begin
      @(negedge clk);
      waitCnt++;
    end
    bus.in_num   = num;
    bus.in_den   = den;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    checkOutput("issueAvail", 32'(bus.gcd_input_available), 32'd1);
    checkOutput("gcdA", 32'(bus.gcd_a), 32'(num));
    checkOutput("gcdB", 32'(bus.gcd_b), 32'(den));
    checkOutput("inReadyBusy", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    bus.gcd_idle = 1'b1;
    @(negedge clk);
    bus.gcd_idle = 1'b0;
    #1;
    checkOutput("takenEarly", 32'(bus.gcd_result_taken), 32'd0);
    @(negedge clk);
    bus.gcd_out              = g;
    bus.gcd_result_available = 1'b1;
    #1;
    checkOutput("resultTaken", 32'(bus.gcd_result_taken), 32'd1);
    latOut = 0;
    do begin
      @(negedge clk);
      latOut++;
      if (latOut == 1) bus.gcd_result_available = 1'b0;
    end while (!bus.out_valid && latOut < 40);
  endtask

  // Completes the output handshake and checks the block is ready again.
  task automatic finishOp();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    #1;
    checkOutput("readyAfterDone", 32'(bus.in_ready), 32'd1);
    checkOutput("validAfterDone", 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    testsRun  = 0;
    failCount = 0;
    reset     = 1'b0;
    bus.in_num = '0;
    bus.in_den = '0;
    bus.in_valid = 1'b0;
    bus.gcd_idle = 1'b0;
    bus.gcd_result_available = 1'b0;
    bus.gcd_out = '0;
    bus.out_ready = 1'b0;

    // Reset values.
    repeat (3) @(negedge clk);
    checkOutput("rstInReady", 32'(bus.in_ready), 32'd0);
    checkOutput("rstIssue", 32'(bus.gcd_input_available), 32'd0);
    checkOutput("rstTaken", 32'(bus.gcd_result_taken), 32'd0);
    checkOutput("rstValid", 32'(bus.out_valid), 32'd0);
    checkOutput("rstOutNum", 32'(bus.out_num), 32'd0);
    checkOutput("rstOutDen", 32'(bus.out_den), 32'd0);
    checkOutput("rstUndef", 32'(bus.out_undef), 32'd0);
    checkOutput("rstGcdA", 32'(bus.gcd_a), 32'd0);
    checkOutput("rstGcdB", 32'(bus.gcd_b), 32'd0);
    reset = 1'b1;
    #1;
    checkOutput("relInReady", 32'(bus.in_ready), 32'd1);

    // 12/18, g=6 -> 2/3
    applyStimulus(8'd12, 8'd18, 8'd6, lat);
    checkOutput("p12p18Lat", 32'(lat), 32'(FullLat));
    checkOutput("p12p18Num", 32'(bus.out_num), 32'h002);
    checkOutput("p12p18Den", 32'(bus.out_den), 32'd3);
    checkOutput("p12p18Undef", 32'(bus.out_undef), 32'd0);
    finishOp();

    // -12/18 -> -2/3
    applyStimulus(8'hF4, 8'd18, 8'd6, lat);
    checkOutput("m12p18Num", 32'(bus.out_num), 32'h1FE);
    checkOutput("m12p18Den", 32'(bus.out_den), 32'd3);
    finishOp();

    // 12/-18 -> -2/3
    applyStimulus(8'd12, 8'hEE, 8'd6, lat);
    checkOutput("p12m18Num", 32'(bus.out_num), 32'h1FE);
    checkOutput("p12m18Den", 32'(bus.out_den), 32'd3);
    finishOp();

    // -12/-18 -> +2/3
    applyStimulus(8'hF4, 8'hEE, 8'd6, lat);
    checkOutput("m12m18Num", 32'(bus.out_num), 32'h002);
    checkOutput("m12m18Den", 32'(bus.out_den), 32'd3);
    finishOp();

    // -128/-1, g=1 -> +128/1
    applyStimulus(8'h80, 8'hFF, 8'd1, lat);
    checkOutput("m128m1Lat", 32'(lat), 32'(UnityLat));
    checkOutput("m128m1Num", 32'(bus.out_num), 32'h080);
    checkOutput("m128m1Den", 32'(bus.out_den), 32'd1);
    finishOp();

    // 0/0, g=0 -> 0/0 undefined, no divide
    applyStimulus(8'd0, 8'd0, 8'd0, lat);
    checkOutput("z0z0Lat", 32'(lat), 32'd1);
    checkOutput("z0z0Num", 32'(bus.out_num), 32'd0);
    checkOutput("z0z0Den", 32'(bus.out_den), 32'd0);
    checkOutput("z0z0Undef", 32'(bus.out_undef), 32'd1);
    finishOp();

    // 5/0, g=5 -> 1/0 undefined
    applyStimulus(8'd5, 8'd0, 8'd5, lat);
    checkOutput("p5z0Num", 32'(bus.out_num), 32'd1);
    checkOutput("p5z0Den", 32'(bus.out_den), 32'd0);
    checkOutput("p5z0Undef", 32'(bus.out_undef), 32'd1);
    finishOp();

    // 0/-7, g=7 -> 0/1, zero numerator keeps a non-negative sign
    applyStimulus(8'd0, 8'hF9, 8'd7, lat);
    checkOutput("z0m7Num", 32'(bus.out_num), 32'd0);
    checkOutput("z0m7Den", 32'(bus.out_den), 32'd1);
    checkOutput("z0m7Undef", 32'(bus.out_undef), 32'd0);
    finishOp();

    // 9/6, g=3 -> 3/2 with out_ready held low for five cycles
    applyStimulus(8'd9, 8'd6, 8'd3, lat);
    for (int i = 0; i < 5; i++) begin
      checkOutput("holdValid", 32'(bus.out_valid), 32'd1);
      checkOutput("holdNum", 32'(bus.out_num), 32'd3);
      checkOutput("holdDen", 32'(bus.out_den), 32'd2);
      checkOutput("holdInReady", 32'(bus.in_ready), 32'd0);
      @(negedge clk);
    end
    finishOp();

    // Reset asserted while the numerator divide is running.
    bus.in_num   = 8'd12;
    bus.in_den   = 8'd18;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.gcd_idle = 1'b1;
    @(negedge clk);
    bus.gcd_idle = 1'b0;
    bus.gcd_out  = 8'd6;
    bus.gcd_result_available = 1'b1;
    @(negedge clk);
    bus.gcd_result_available = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("midRstValid", 32'(bus.out_valid), 32'd0);
    checkOutput("midRstInReady", 32'(bus.in_ready), 32'd0);
    checkOutput("midRstGcdA", 32'(bus.gcd_a), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("postRstInReady", 32'(bus.in_ready), 32'd1);
    applyStimulus(8'd9, 8'd6, 8'd3, lat);
    checkOutput("postRstLat", 32'(lat), 32'(FullLat));
    checkOutput("postRstNum", 32'(bus.out_num), 32'd3);
    checkOutput("postRstDen", 32'(bus.out_den), 32'd2);
    finishOp();

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
